// File: rtl/handshake_pkg.sv
// handshake_pkg: shared FIFO state encoding, error counter width and saturating increment.
package handshake_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_e;
  localparam int ERR_CNT_W = 16;
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/handshake_const_check_if.sv
// handshake_const_check_if: input token channel, match-result channel and error status.
interface handshake_const_check_if import handshake_pkg::*; #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic ins_valid, ins_ready, outs, outs_valid, outs_ready, err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (output ins, ins_valid, outs_ready, input ins_ready, outs, outs_valid, err_count, err_sticky);
  modport slave (input ins, ins_valid, outs_ready, output ins_ready, outs, outs_valid, err_count, err_sticky);
endinterface

// File: rtl/handshake_fifo2.sv
// handshake_fifo2: 2-entry, 1-bit payload FIFO; in_ready_o is registered so it never sees out_ready_i combinationally.
module handshake_fifo2 import handshake_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  input  logic in_data_i,
  output logic in_ready_o,
  output logic out_valid_o,
  output logic out_data_o,
  input  logic out_ready_i
);
  fifo_state_e state_q, state_d;
  logic head_q, head_d, tail_q, tail_d, ready_q, push, pop;
  assign push = in_valid_i & ready_q;
  assign pop = out_valid_o & out_ready_i;
  assign in_ready_o = ready_q;
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o = head_q;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      EMPTY: begin
        state_d = push ? ONE : EMPTY;
        head_d = push ? in_data_i : head_q;
      end
      ONE: begin
        state_d = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
        head_d = (push && pop) ? in_data_i : head_q;
        tail_d = push ? in_data_i : tail_q;
      end
      FULL: begin
        state_d = pop ? ONE : FULL;
        head_d = pop ? tail_q : head_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? state_d : EMPTY;
    head_q <= rst & head_d;
    tail_q <= rst & tail_d;
    ready_q <= rst && state_d != FULL;
  end
endmodule

// File: rtl/handshake_const_check.sv
// handshake_const_check: compares each accepted token with EXPECTED and queues the match bit.
// Define HANDSHAKE_CONST_CHECK_STATS_EN to compile in the saturating err_count counter.
module handshake_const_check import handshake_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED = '0
) (
  input logic clk,
  input logic rst,
  handshake_const_check_if.slave bus
);
  logic match, mismatch_acc, err_sticky_q;
  assign match = bus.ins == EXPECTED;
  assign mismatch_acc = bus.ins_valid & bus.ins_ready & ~match;
  handshake_fifo2 u_fifo (
    .clk(clk),
    .rst(rst),
    .in_valid_i(bus.ins_valid),
    .in_data_i(match),
    .in_ready_o(bus.ins_ready),
    .out_valid_o(bus.outs_valid),
    .out_data_o(bus.outs),
    .out_ready_i(bus.outs_ready)
  );
  always_ff @(posedge clk) err_sticky_q <= rst & (err_sticky_q | mismatch_acc);
  assign bus.err_sticky = err_sticky_q;
`ifdef HANDSHAKE_CONST_CHECK_STATS_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  always_comb err_cnt_d = mismatch_acc ? sat_inc(err_cnt_q) : err_cnt_q;
  always_ff @(posedge clk) err_cnt_q <= rst ? err_cnt_d : '0;
  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif
endmodule
